// File: rtl/bcd_display_driver.sv
// bcd_display_driver: binary to four-digit 7-segment display stage.
// Double-dabble conversion, one bit per clock; display held while busy.
module bcd_display_driver #(
   parameter int DATA_W   = 32,
   parameter int DIGITS   = 4,
   parameter bit AUTO     = 1'b1,
   parameter bit BLANK_LZ = 1'b0
) (
   input  logic              clock,
   input  logic              n_reset,
   input  logic [DATA_W-1:0] binary,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [6:0]        ones,
   output logic [6:0]        tens,
   output logic [6:0]        hundreds,
   output logic [6:0]        thousands
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(DATA_W + 1);

   localparam logic [DATA_W-1:0] MAX_VAL =
      DATA_W'(10 ** DIGITS - 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_W);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CONV = 2'd1;
   localparam logic [1:0] S_UPD  = 2'd2;

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   logic [1:0]             state;
   logic [DATA_W-1:0]      shift_q;
   logic [DATA_W-1:0]      shift_nxt;
   logic [DATA_W-1:0]      last_q;
   logic [BW-1:0]          bcd_q;
   logic [BW-1:0]          bcd_adj;
   logic [BW-1:0]          bcd_nxt;
   logic [CW-1:0]          cnt_q;
   logic                   ovf_pend;
   logic                   capture;
   logic                   lz_run;
   logic [DIGITS-1:0][6:0] seg_q;
   logic [DIGITS-1:0][6:0] seg_nxt;

   function automatic logic [6:0] seg7(
      input logic [3:0] n
   );
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   assign capture = (state == S_IDLE) &&
                    (start ||
                     (AUTO && (binary != last_q)));

   // add 3 to every BCD nibble of 5 or more ahead of the shift
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   assign bcd_nxt   = {bcd_adj[BW-2:0], shift_q[DATA_W-1]};
   assign shift_nxt = {shift_q[DATA_W-2:0], 1'b0};

   // segment images of the finished result, dashes on overflow
   always_comb begin
      seg_nxt = '0;
      lz_run  = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (ovf_pend)
            seg_nxt[i] = SEG_DASH;
         else if (BLANK_LZ && lz_run && (i != 0) &&
                  (bcd_q[4*i +: 4] == 4'd0))
            seg_nxt[i] = SEG_BLANK;
         else
            seg_nxt[i] = seg7(bcd_q[4*i +: 4]);
         if (bcd_q[4*i +: 4] != 4'd0)
            lz_run = 1'b0;
      end
   end

   // capture, convert one bit per clock, then publish in one cycle
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         seg_q    <= {DIGITS{SEG_BLANK}};
         last_q   <= '0;
         shift_q  <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         ovf_pend <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (capture) begin
                  shift_q  <= binary;
                  last_q   <= binary;
                  bcd_q    <= '0;
                  ovf_pend <= (binary > MAX_VAL);
                  cnt_q    <= CNT_LOAD;
                  busy     <= 1'b1;
                  state    <= S_CONV;
               end
            end
            S_CONV: begin
               bcd_q   <= bcd_nxt;
               shift_q <= shift_nxt;
               cnt_q   <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  busy  <= 1'b0;
                  state <= S_UPD;
               end
            end
            S_UPD: begin
               seg_q    <= seg_nxt;
               overflow <= ovf_pend;
               done     <= 1'b1;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign ones      = seg_q[0];
   assign tens      = seg_q[1];
   assign hundreds  = seg_q[2];
   assign thousands = seg_q[3];

endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver: three configurations against a digit-level
// model; per-cycle compare plus hand-computed literal checks.
module tb_bcd_display_driver;

   localparam bit [2:0] AUTO_P = 3'b010;
   localparam bit [2:0] BLZ_P  = 3'b100;

   typedef struct packed {
      int          ph;
      logic [31:0] cap;
      logic [31:0] last;
      logic [30:0] e;
   } mdl_t;

   logic        clock = 1'b0;
   logic        n_reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] binary = '0;

   logic        busy_o [3];
   logic        done_o [3];
   logic        ovf_o  [3];
   logic [6:0]  on_o   [3];
   logic [6:0]  te_o   [3];
   logic [6:0]  hu_o   [3];
   logic [6:0]  th_o   [3];
   logic [30:0] act    [3];
   mdl_t        mdl    [3];

   int compared = 0;
   int mismatched = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      bcd_display_driver #(
         .DATA_W   (32),
         .DIGITS   (4),
         .AUTO     (AUTO_P[g]),
         .BLANK_LZ (BLZ_P[g])
      ) u_dut (
         .clock     (clock),
         .n_reset   (n_reset),
         .binary    (binary),
         .start     (start),
         .busy      (busy_o[g]),
         .done      (done_o[g]),
         .overflow  (ovf_o[g]),
         .ones      (on_o[g]),
         .tens      (te_o[g]),
         .hundreds  (hu_o[g]),
         .thousands (th_o[g])
      );
      assign act[g] = {busy_o[g], done_o[g], ovf_o[g],
                       th_o[g], hu_o[g], te_o[g], on_o[g]};
   end

   function automatic logic [6:0] seg7(int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // display image of a value: decimal digits by division
   function automatic logic [27:0] show(logic [31:0] v, bit blz);
      logic [27:0] r;
      logic [31:0] p;
      int          d;
      r = '0;
      p = 32'd1;
      if (v > 32'd9999) return {4{7'b0111111}};
      for (int i = 0; i < 4; i++) begin
         d = int'((v / p) % 32'd10);
         if (blz && i > 0 && v < p)
            r[7*i +: 7] = 7'b1111111;
         else
            r[7*i +: 7] = seg7(d);
         p = p * 32'd10;
      end
      return r;
   endfunction

   function automatic mdl_t rst_m();
      mdl_t m;
      m.ph = -1;
      m.cap = '0;
      m.last = '0;
      m.e = 31'h0fffffff;
      return m;
   endfunction

   // ph counts edges since capture; result lands 33 edges later
   function automatic mdl_t step(mdl_t m, bit au, bit blz,
                                 logic st, logic [31:0] bin);
      mdl_t n;
      n = m;
      n.e[29] = 1'b0;
      if (m.ph < 0) begin
         if (st || (au && bin != m.last)) begin
            n.cap = bin;
            n.last = bin;
            n.ph = 0;
            n.e[30] = 1'b1;
         end
      end else begin
         n.ph = m.ph + 1;
         if (n.ph == 32) n.e[30] = 1'b0;
         if (n.ph == 33) begin
            n.ph = -1;
            n.e[29] = 1'b1;
            n.e[28] = (m.cap > 32'd9999);
            n.e[27:0] = show(m.cap, blz);
         end
      end
      return n;
   endfunction

   always @(posedge clock or negedge n_reset) begin
      for (int g = 0; g < 3; g++) begin
         if (!n_reset)
            mdl[g] <= rst_m();
         else
            mdl[g] <= step(mdl[g], AUTO_P[g], BLZ_P[g],
                           start, binary);
      end
   end

   always @(negedge clock) begin
      for (int g = 0; g < 3; g++) begin
         compared++;
         if (act[g] !== mdl[g].e) begin
            mismatched++;
            $display("FAIL cycle dut%0d t=%0t got %h want %h",
                     g, $time, act[g], mdl[g].e);
         end
      end
   end

   task automatic chk(string nm, logic [31:0] a, logic [31:0] x);
      compared++;
      if (a !== x) begin
         mismatched++;
         $display("FAIL %s: got %h want %h", nm, a, x);
      end
   endtask

   task automatic idle(int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic run_start(input logic [31:0] v, input int g,
                            output int lat, output int bc);
      binary = v;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      lat = 0;
      bc = 0;
      while (!done_o[g] && lat < 200) begin
         if (busy_o[g]) bc++;
         @(negedge clock);
         lat++;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bc, k, bad, r;
      #2 n_reset = 1'b0;
      idle(3);
      chk("reset_state", act[0], 31'h0fffffff);
      n_reset = 1'b1;
      idle(4);
      chk("auto_zero_no_conv", {busy_o[1], done_o[1]}, 0);

      run_start(32'd1234, 0, lat, bc);
      chk("lat_1234", lat, 33);
      chk("busy_1234", bc, 32);
      chk("seg_1234", act[0][27:0],
          {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
      chk("ovf_1234", ovf_o[0], 0);
      idle(2);

      run_start(32'd9999, 0, lat, bc);
      chk("seg_9999", act[0][27:0], {4{7'b0010000}});
      chk("ovf_9999", ovf_o[0], 0);
      idle(2);

      run_start(32'd10000, 0, lat, bc);
      chk("lat_10000", lat, 33);
      chk("seg_10000", act[0][27:0], {4{7'b0111111}});
      chk("ovf_10000", ovf_o[0], 1);
      idle(2);

      run_start(32'd7, 2, lat, bc);
      chk("blz_7", act[2][27:0],
          {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000});
      idle(2);
      run_start(32'd0, 2, lat, bc);
      chk("blz_0", act[2][27:0],
          {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
      idle(40);

      binary = 32'd42;
      idle(5);
      binary = 32'd57;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      k = 0;
      while (!done_o[1] && k < 200) begin
         @(negedge clock);
         k++;
      end
      chk("auto_first_0042", act[1][27:0],
          {7'b1000000, 7'b1000000, 7'b0011001, 7'b0100100});
      @(negedge clock);
      k = 1;
      while (!done_o[1] && k < 200) begin
         @(negedge clock);
         k++;
      end
      chk("auto_spacing", k, 34);
      chk("auto_second_0057", act[1][27:0],
          {7'b1000000, 7'b1000000, 7'b0010010, 7'b1111000});
      bc = 0;
      repeat (80) begin
         @(negedge clock);
         if (done_o[1]) bc++;
      end
      chk("auto_no_extra_done", bc, 0);

      binary = 32'd5678;
      idle(10);
      #2 n_reset = 1'b0;
      #1 chk("async_reset", act[1], 31'h0fffffff);
      @(negedge clock);
      n_reset = 1'b1;
      lat = 0;
      bad = 0;
      while (!done_o[1] && lat < 200) begin
         if (act[1][27:0] !== 28'hfffffff) bad++;
         @(negedge clock);
         lat++;
      end
      chk("rst_restart_lat", lat, 34);
      chk("rst_blank_hold", bad, 0);
      chk("rst_seg_5678", act[1][27:0],
          {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000});
      idle(2);

      repeat (300) begin
         r = $urandom_range(0, 9);
         if (r <= 3)
            binary = $urandom_range(0, 9999);
         else if (r <= 5)
            binary = $urandom_range(9990, 10010);
         else if (r == 6)
            binary = $urandom;
         else if (r == 7)
            binary = $urandom_range(0, 99);
         start = ($urandom_range(0, 2) == 0);
         @(negedge clock);
         start = 1'b0;
         idle($urandom_range(0, 45));
         if ($urandom_range(0, 19) == 0) begin
            #2 n_reset = 1'b0;
            @(negedge clock);
            n_reset = 1'b1;
         end
      end
      idle(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/bcd_display_driver.md
Name: bcd_display_driver

Overview:
Sequential binary-to-7-segment display stage on the processor's display path. It consumes the 32-bit register value selected for display and drives the four decimal-digit 7-segment outputs. Conversion uses a shift-and-add-3 (double-dabble) FSM, one bit per cycle. The last valid display is held during conversion, so the digits never flicker.

Parameters:
DATA_W, 32, width of the binary input; conversion takes exactly DATA_W cycles
DIGITS, 4, number of decimal digits; the display range is 0 .. 10^DIGITS-1 (9999)
AUTO, 1, 1 = restart conversion automatically when binary differs from the last converted value; 0 = convert only on start
BLANK_LZ, 0, 1 = blank leading zero digits (the ones digit is never blanked)

Ports:
clock  input  1  system clock; all state changes on the rising edge
n_reset  input  1  asynchronous, active-low reset
binary  input  DATA_W  unsigned value to display
start  input  1  single-cycle conversion request
busy  output  1  high while converting
done  output  1  one-cycle pulse when the displays update
overflow  output  1  registered; high when the displayed value is >= 10^DIGITS
ones  output  7  segment digit 0
tens  output  7  segment digit 1
hundreds  output  7  segment digit 2
thousands  output  7  segment digit 3

Behaviour:
- Clock and reset: one clock, `clock`. Reset `n_reset` is asynchronous and active-low.
- Reset values: FSM in IDLE; busy=0, done=0, overflow=0; all digit outputs blank (7'b1111111); last-value register = 0.
- Segment encoding:
  - Bit order {g,f,e,d,c,b,a}, active-low.
  - Digits 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Dash = 0111111. Blank = 1111111.
- State IDLE:
  - Capture binary into the shift register and last-value register if start=1, or if AUTO=1 and binary != last-value.
  - On capture: clear the BCD accumulator, set ovf_pend = (binary > 10^DIGITS-1), load bit counter = DATA_W, go to CONVERT. busy rises the next cycle.
- State CONVERT, once per cycle:
  - Each BCD nibble >= 5 gets +3.
  - Then {bcd, shift} shifts left by 1; the counter decrements.
  - BCD bits above 4*DIGITS are discarded.
  - When the counter reaches 0, go to UPDATE.
- State UPDATE (one cycle):
  - Register the segment outputs and overflow = ovf_pend; pulse done=1; busy=0; return to IDLE.
  - If ovf_pend: all four digits show dash.
  - Else each nibble is encoded. With BLANK_LZ=1, leading zero digits above the most significant nonzero digit are blank, and ones always shows a digit.
- Latency: capture on edge 0; done and new outputs are visible after edge DATA_W+1 (33 cycles at the default). The latency is constant, including for overflow values.
- start while busy: ignored, not queued.
- AUTO change during CONVERT: the captured value is completed first. IDLE then re-evaluates the following cycle and restarts, so the minimum spacing between done pulses is DATA_W+2 cycles.
- start and an AUTO change in the same IDLE cycle: a single capture.
- Outputs, overflow and busy hold between updates; done is high for exactly 1 cycle.
- n_reset asserted mid-conversion: immediate abort, reset values restored. After release, with AUTO=1 and binary != 0, conversion restarts automatically.
- Value 0 with BLANK_LZ=0 shows 0000; with BLANK_LZ=1 it shows blank, blank, blank, 0.

Test Plan:
- Assert n_reset=0 mid-stream, then release -> immediately busy=0, done=0, overflow=0, all digits 1111111. With binary=0 and AUTO=1 no conversion starts.
- binary=1234, start pulse (AUTO=0) -> busy high for 32 cycles, then done on cycle 33. thousands=1111001, hundreds=0100100, tens=0110000, ones=0011001, overflow=0.
- binary=9999, then binary=10000 -> first: all digits 0010000, overflow=0. Second: all digits 0111111, overflow=1, same 33-cycle latency.
- BLANK_LZ=1: binary=7 -> thousands, hundreds and tens 1111111, ones 1111000. binary=0 -> ones 1000000.
- AUTO=1: binary changes 42->57 mid-conversion, and start is pulsed during busy -> first done shows 0042. A second done follows DATA_W+2 cycles later showing 0057. No extra conversion occurs for the start pulse.
- n_reset pulsed at cycle 10 of a conversion of 5678 -> outputs are blank until the restarted conversion completes. done then shows 5678 exactly 33 cycles after reset release + 1.
